// File: rtl/stopwatch_core.sv
// MM:SS BCD counting engine with run/pause, clear and per-field adjust.
// Button inputs are synchronized here; ticks arrive already in the clk domain.
module stopwatch_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause,
    input  logic       clear,
    input  logic       adj,
    input  logic       sel,
    output logic [4:0] min_l,
    output logic [4:0] min_r,
    output logic [4:0] sec_l,
    output logic [4:0] sec_r,
    output logic       running
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    // Lane order: 0 = pause, 1 = clear, 2 = adj, 3 = sel
    logic [3:0] btn_raw;
    logic [3:0] sync1_q, sync2_q;
    logic [1:0] edge_q;
    logic       pause_p, clear_p, adj_s, sel_s;

    state_t     state_q, state_d;
    logic       resume_paused_q, resume_paused_d;
    logic       running_q, running_d;
    logic [4:0] min_l_q, min_r_q, sec_l_q, sec_r_q;
    logic [4:0] min_l_d, min_r_d, sec_l_d, sec_r_d;

    assign btn_raw = {sel, adj, clear, pause};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q[1:0];
        end
    end

    assign pause_p = sync2_q[0] & ~edge_q[0];
    assign clear_p = sync2_q[1] & ~edge_q[1];
    assign adj_s   = sync2_q[2];
    assign sel_s   = sync2_q[3];

    // Two-digit BCD increment that wraps 59 -> 00.
    function automatic logic [9:0] pair_inc(input logic [4:0] tens, input logic [4:0] units);
        logic [9:0] r;
        if (units == 5'd9) begin
            if (tens == 5'd5) r = {5'd0, 5'd0};
            else              r = {tens + 5'd1, 5'd0};
        end else begin
            r = {tens, units + 5'd1};
        end
        return r;
    endfunction

    function automatic logic pair_max(input logic [4:0] tens, input logic [4:0] units);
        return (tens == 5'd5) && (units == 5'd9);
    endfunction

    // Digit next-state: clear beats any tick; increment uses the pre-transition state.
    always_comb begin
        min_l_d = min_l_q;
        min_r_d = min_r_q;
        sec_l_d = sec_l_q;
        sec_r_d = sec_r_q;
        if (clear_p) begin
            min_l_d = 5'd0;
            min_r_d = 5'd0;
            sec_l_d = 5'd0;
            sec_r_d = 5'd0;
        end else if (state_q == ST_RUN && tick_1hz) begin
            {sec_l_d, sec_r_d} = pair_inc(sec_l_q, sec_r_q);
            if (pair_max(sec_l_q, sec_r_q)) begin
                {min_l_d, min_r_d} = pair_inc(min_l_q, min_r_q);
            end
        end else if (state_q == ST_ADJUST && tick_2hz) begin
            if (sel_s) {sec_l_d, sec_r_d} = pair_inc(sec_l_q, sec_r_q);
            else       {min_l_d, min_r_d} = pair_inc(min_l_q, min_r_q);
        end
    end

    // Entering ADJUST takes precedence over a pause pulse in the same cycle.
    always_comb begin
        state_d         = state_q;
        resume_paused_d = resume_paused_q;
        case (state_q)
            ST_RUN: begin
                if (adj_s) begin
                    resume_paused_d = 1'b0;
                    state_d         = ST_ADJUST;
                end else if (pause_p) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (adj_s) begin
                    resume_paused_d = 1'b1;
                    state_d         = ST_ADJUST;
                end else if (pause_p) begin
                    state_d = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (!adj_s) state_d = resume_paused_q ? ST_PAUSED : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RUN;
            resume_paused_q <= 1'b0;
            running_q       <= 1'b1;
            min_l_q         <= 5'd0;
            min_r_q         <= 5'd0;
            sec_l_q         <= 5'd0;
            sec_r_q         <= 5'd0;
        end else begin
            state_q         <= state_d;
            resume_paused_q <= resume_paused_d;
            running_q       <= running_d;
            min_l_q         <= min_l_d;
            min_r_q         <= min_r_d;
            sec_l_q         <= sec_l_d;
            sec_r_q         <= sec_r_d;
        end
    end

    assign min_l   = min_l_q;
    assign min_r   = min_r_q;
    assign sec_l   = sec_l_q;
    assign sec_r   = sec_r_q;
    assign running = running_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomized and directed bench for stopwatch_core against a seconds-count model.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
    logic       pause = 1'b0, clear = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [4:0] min_l, min_r, sec_l, sec_r;
    logic       running;

    stopwatch_core dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause(pause), .clear(clear), .adj(adj), .sel(sel),
        .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
        .running(running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: count as total seconds, mode 0=run 1=paused 2=adjust.
    int m_secs = 0;
    int m_mode = 0;
    int m_resume = 0;
    // Level history, [0] = value seen at the most recent edge.
    bit [2:0] hp = 0, hc = 0, ha = 0, hs = 0;
    bit p_lvl = 0, c_lvl = 0, a_lvl = 0, s_lvl = 0;

    function automatic int dut_time();
        return min_l * 1000 + min_r * 100 + sec_l * 10 + sec_r;
    endfunction

    function automatic int model_time();
        return (m_secs / 600) * 1000 + ((m_secs / 60) % 10) * 100
             + ((m_secs % 60) / 10) * 10 + (m_secs % 10);
    endfunction

    task automatic model_reset();
        m_secs = 0; m_mode = 0; m_resume = 0;
        hp = 0; hc = 0; ha = 0; hs = 0;
    endtask

    // A level seen at edge e is acted on at edge e+2.
    task automatic model_edge(input bit t1, input bit t2);
        bit adj_e, sel_e, pp, cp;
        int mm, ss, nmode;
        adj_e = ha[1];
        sel_e = hs[1];
        pp    = hp[1] & ~hp[2];
        cp    = hc[1] & ~hc[2];
        if (cp) m_secs = 0;
        else if (m_mode == 0 && t1) m_secs = (m_secs + 1) % 3600;
        else if (m_mode == 2 && t2) begin
            mm = m_secs / 60; ss = m_secs % 60;
            if (sel_e) ss = (ss + 1) % 60;
            else       mm = (mm + 1) % 60;
            m_secs = mm * 60 + ss;
        end
        nmode = m_mode;
        if (m_mode == 2) begin
            if (!adj_e) nmode = m_resume;
        end else if (adj_e) begin
            m_resume = m_mode;
            nmode = 2;
        end else if (pp) begin
            nmode = 1 - m_mode;
        end
        m_mode = nmode;
        hp = {hp[1:0], p_lvl}; hc = {hc[1:0], c_lvl};
        ha = {ha[1:0], a_lvl}; hs = {hs[1:0], s_lvl};
    endtask

    // One clock: drive at negedge, advance model at posedge, compare 1 ns later.
    task automatic cyc(input bit t1, input bit t2);
        int exp_t, exp_r;
        @(negedge clk);
        tick_1hz = t1; tick_2hz = t2;
        pause = p_lvl; clear = c_lvl; adj = a_lvl; sel = s_lvl;
        @(posedge clk);
        model_edge(t1, t2);
        #1;
        exp_t = model_time();
        exp_r = (m_mode == 0) ? 1 : 0;
        checks++;
        if (dut_time() != exp_t || int'(running) != exp_r) begin
            failures++;
            $display("FAIL cycle_compare t=%0t actual=%04d run=%0d required=%04d run=%0d",
                     $time, dut_time(), running, exp_t, exp_r);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0);
    endtask

    task automatic tick1(input int n);
        repeat (n) begin cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); end
    endtask

    // Interleaves ignored 1 Hz ticks with the adjust ticks.
    task automatic tick2(input int n);
        repeat (n) begin cyc(1'b1, 1'b1); cyc(1'b0, 1'b0); end
    endtask

    task automatic press_pause();
        p_lvl = 1; idle(4); p_lvl = 0; idle(3);
    endtask

    initial begin
        bit pt1, pt2, t1, t2;
        pt1 = 0; pt2 = 0;

        repeat (2) @(negedge clk);
        chk("reset_time", dut_time(), 0);
        chk("reset_running", int'(running), 1);
        rst = 0;
        model_reset();

        tick1(75);
        chk("count_75", dut_time(), 115);
        chk("count_75_running", int'(running), 1);
        tick1(3525);
        chk("count_3600_wrap", dut_time(), 0);

        a_lvl = 1; s_lvl = 0; idle(4);
        tick2(59);
        s_lvl = 1; idle(3);
        tick2(58);
        a_lvl = 0; idle(4);
        chk("preload_5958", dut_time(), 5958);
        chk("preload_running", int'(running), 1);
        tick1(1);
        chk("count_5959", dut_time(), 5959);
        tick1(1);
        chk("wrap_0000", dut_time(), 0);

        tick1(10);
        press_pause();
        tick1(5);
        chk("paused_hold", dut_time(), 10);
        chk("paused_running", int'(running), 0);
        press_pause();
        tick1(1);
        chk("resumed_0011", dut_time(), 11);
        chk("resumed_running", int'(running), 1);

        a_lvl = 1; s_lvl = 1; idle(4);
        tick2(47);
        chk("adj_to_0058", dut_time(), 58);
        tick2(3);
        chk("adj_sec_wrap", dut_time(), 1);
        s_lvl = 0; idle(3);
        tick2(2);
        chk("adj_min_0201", dut_time(), 201);
        a_lvl = 0; idle(4);
        chk("adj_exit_run", int'(running), 1);

        press_pause();
        a_lvl = 1; idle(4);
        chk("adj_from_paused", int'(running), 0);
        press_pause();
        a_lvl = 0; idle(4);
        chk("back_to_paused", int'(running), 0);
        press_pause();
        chk("paused_to_run", int'(running), 1);

        a_lvl = 1; s_lvl = 0; idle(4);
        tick2(10);
        s_lvl = 1; idle(3);
        tick2(33);
        a_lvl = 0; idle(4);
        chk("preload_1234", dut_time(), 1234);
        c_lvl = 1;
        idle(2);
        cyc(1'b1, 1'b0);
        chk("clear_beats_tick", dut_time(), 0);
        chk("clear_keeps_run", int'(running), 1);
        idle(3);
        c_lvl = 0; idle(4);
        chk("clear_release_noop", dut_time(), 0);

        for (int i = 0; i < 3000; i++) begin
            t1 = !pt1 && ($urandom_range(0, 3) == 0);
            t2 = !pt2 && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) p_lvl = ~p_lvl;
            if ($urandom_range(0, 79) == 0) c_lvl = ~c_lvl;
            if ($urandom_range(0, 59) == 0) a_lvl = ~a_lvl;
            if ($urandom_range(0, 29) == 0) s_lvl = ~s_lvl;
            cyc(t1, t2);
            pt1 = t1; pt2 = t2;
        end

        p_lvl = 0; c_lvl = 0; a_lvl = 0; s_lvl = 0;
        idle(5);
        if (m_mode == 1) press_pause();
        tick1(7);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("async_rst_time", dut_time(), 0);
        chk("async_rst_running", int'(running), 1);
        @(negedge clk);
        rst = 0;
        model_reset();
        tick1(3);
        chk("after_rst_count", dut_time(), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=timeout required=finish");
        $fatal(1);
    end

endmodule
